// File: rtl/instr_fetch_unit.sv
// Fetch stage of the single-cycle RV32 core. It owns the PC, runs the request/response
// handshake with instruction memory and presents one instruction at a time to decode.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_ready,
  input  logic             imem_rvalid,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      instr,
  output logic [31:0]      instr_pc,
  output logic [31:0]      pc_plus4,
  output logic             instr_valid,
  input  logic             stall,
  input  logic             branch_beq,
  input  logic             branch_jal,
  input  logic             branch_jalr,
  input  logic             zero,
  input  logic [31:0]      imm,
  input  logic [31:0]      alu_result,
  output logic             misaligned,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {FETCH, WAIT, ISSUE, DRAIN, HALT} state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] next_pc;

  // jalr wins over jal, which wins over a taken beq; everything wraps modulo 2^32.
  function automatic logic [31:0] next_pc_calc(
    input logic [31:0] cur_pc,
    input logic        beq,
    input logic        jal,
    input logic        jalr,
    input logic        z,
    input logic [31:0] offset,
    input logic [31:0] alu
  );
    logic [31:0] target;
    target = cur_pc + 32'd4;
    if (jalr)
      target = alu & 32'hFFFF_FFFE;
    else if (jal || (beq && z))
      target = cur_pc + offset;
    return target;
  endfunction

  always_comb begin
    next_pc = next_pc_calc(instr_pc, branch_beq, branch_jal, branch_jalr, zero, imm, alu_result);
  end

  assign imem_req  = (state == FETCH) && !reset;
  assign imem_addr = pc;
  assign pc_plus4  = instr_pc + 32'd4;

  always_ff @(posedge clk) begin
    if (reset) begin
      // A response already promised to the old WAIT must still be absorbed.
      state       <= (state == WAIT) ? DRAIN : FETCH;
      pc          <= RESET_PC;
      instr       <= '0;
      instr_valid <= 1'b0;
      misaligned  <= 1'b0;
      retired     <= '0;
    end else begin
      case (state)
        FETCH: begin
          if (imem_ready)
            state <= WAIT;
        end
        WAIT: begin
          if (imem_rvalid) begin
            instr       <= imem_rdata;
            instr_pc    <= pc;
            instr_valid <= 1'b1;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          if (!stall) begin
            retired     <= retired + CNT_W'(1);
            instr_valid <= 1'b0;
            pc          <= next_pc;
            if (next_pc[1:0] != 2'b00) begin
              misaligned <= 1'b1;
              state      <= HALT;
            end else begin
              state <= FETCH;
            end
          end
        end
        DRAIN: begin
          if (imem_rvalid)
            state <= FETCH;
        end
        HALT: begin
          state <= HALT;
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage that sits directly upstream of the instruction decoder and control unit in the single-cycle RV32 core.
- Owns the PC register and runs a request/response handshake with instruction memory.
- Presents one instruction at a time, with its PC, to decode.
- Computes the next PC from the branch/jump controls and ALU results of the instruction it is currently presenting.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset
CNT_W, 32, width of retired-instruction counter

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
imem_req  out  1  fetch request valid
imem_addr  out  32  fetch address (= pc)
imem_ready  in  1  memory accepts request this cycle
imem_rvalid  in  1  read data valid
imem_rdata  in  32  instruction word
instr  out  32  instruction presented to decode
instr_pc  out  32  PC of instr
pc_plus4  out  32  instr_pc + 4 (link value for jal/jalr)
instr_valid  out  1  instr/instr_pc valid
stall  in  1  downstream cannot consume instr this cycle
branch_beq  in  1  from control unit
branch_jal  in  1  from control unit
branch_jalr  in  1  from control unit
zero  in  1  ALU zero flag
imm  in  32  sign-extended immediate of instr
alu_result  in  32  ALU output (jalr target)
misaligned  out  1  sticky: next-PC target not word-aligned
retired  out  CNT_W  count of consumed instructions

Behaviour:
- All state changes on rising clk edge.
- Reset is synchronous, active-high. While reset is sampled high:
  - pc <= RESET_PC; instr <= 0; instr_valid <= 0; misaligned <= 0; retired <= 0.
  - imem_req is forced 0.
  - Next state is DRAIN if the current state is WAIT, otherwise FETCH.
- States: FETCH, WAIT, ISSUE, DRAIN, HALT.
- FETCH:
  - imem_req = 1, imem_addr = pc.
  - imem_ready = 1 -> WAIT; otherwise stay in FETCH with address held stable.
- WAIT:
  - imem_req = 0.
  - imem_rvalid = 1 -> instr <= imem_rdata, instr_pc <= pc, instr_valid <= 1, go to ISSUE.
  - Response may arrive any number of cycles after acceptance, including the next cycle.
- ISSUE:
  - instr_valid = 1. Decode/execute are combinational on instr in this cycle.
  - stall = 1 -> hold everything; branch inputs are ignored.
  - stall = 0 -> instruction consumed: retired += 1 (wraps at 2^CNT_W), instr_valid <= 0, pc <= next_pc, then go to FETCH or HALT.
- DRAIN (stale response after reset mid-WAIT):
  - imem_req = 0.
  - Wait for imem_rvalid, discard the data, then go to FETCH.
- HALT:
  - imem_req = 0, instr_valid = 0. Exits only via reset.
- next_pc, priority order:
  - branch_jalr -> {alu_result[31:1], 1'b0}
  - else branch_jal -> instr_pc + imm
  - else branch_beq & zero -> instr_pc + imm
  - else -> instr_pc + 4
- Arithmetic: all adds are 32-bit modulo 2^32 (wrap-around at 32'hFFFF_FFFC + 4 = 0).
- Alignment: if next_pc[1:0] != 0 at consume:
  - misaligned <= 1, pc <= next_pc, state -> HALT.
  - The instruction still counts as retired.
- pc_plus4 = instr_pc + 4, valid whenever instr_valid = 1.
- imem_rvalid in FETCH, ISSUE or HALT is ignored.
- Minimum throughput is one instruction per 3 cycles (FETCH -> WAIT -> ISSUE) with zero-wait memory and no stall.

Test Plan:
- Sequential fetch: RESET_PC = 0, imem_ready = 1, rvalid the cycle after acceptance, all branches 0, stall = 0 -> imem_addr sequence 0x0, 0x4, 0x8; instr_valid every 3rd cycle; retired = 3 after 9 cycles.
- Branch taken / not taken:
  - At instr_pc = 0x10 with branch_beq = 1, zero = 1, imm = 0xFFFF_FFF8 -> next imem_addr = 0x08.
  - Same with zero = 0 -> next imem_addr = 0x14.
- Priority and jalr masking: branch_jalr = 1 and branch_jal = 1, alu_result = 0x0000_0101, imm = 0x40 -> next imem_addr = 0x100; misaligned stays 0.
- Stall and backpressure:
  - Hold stall = 1 for 4 cycles in ISSUE -> instr and instr_pc stable, retired unchanged, no new imem_req.
  - imem_ready = 0 for 3 cycles in FETCH -> imem_addr stable.
- Misalignment: branch_jal = 1, instr_pc = 0x20, imm = 0x6 -> pc = 0x26, misaligned = 1, imem_req stays 0 until reset.
- Reset mid-WAIT: assert reset for 1 cycle while in WAIT; rvalid with 0xDEAD_BEEF arrives 2 cycles later -> data discarded, instr_valid stays 0, next imem_addr = RESET_PC, retired = 0.
